// File: rtl/classificador_peso_n.sv
// Weight classifier: parses ASCII min/max/current frames from the UART, classifies the
// current weight against the [min, max] window and ramps the servo toward a class target.
module classificador_peso_n #(
    parameter int DIGITS      = 4,
    parameter int W           = 16,
    parameter int POS_W       = 3,
    parameter int STEP_CYCLES = 5_000_000,
    parameter int POS_ABAIXO  = 0,
    parameter int POS_DENTRO  = 7,
    parameter int POS_ACIMA   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    output logic             result_valid,
    output logic             pertence,
    output logic             acima,
    output logic             abaixo,
    output logic             peso_max_zero,
    output logic             erro_quadro,
    output logic [W-1:0]     peso_atual,
    output logic [POS_W-1:0] posicao,
    output logic             movendo
);

    localparam int DCNT_W = $clog2(DIGITS + 1);
    localparam int ICNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [7:0]        CHAR_HASH  = 8'h23;
    localparam logic [DCNT_W-1:0] LAST_DIGIT = DCNT_W'(DIGITS - 1);
    localparam logic [ICNT_W-1:0] LAST_TICK  = ICNT_W'(STEP_CYCLES - 1);
    localparam logic [POS_W-1:0]  TGT_ABAIXO = POS_W'(POS_ABAIXO);
    localparam logic [POS_W-1:0]  TGT_DENTRO = POS_W'(POS_DENTRO);
    localparam logic [POS_W-1:0]  TGT_ACIMA  = POS_W'(POS_ACIMA);

    typedef enum logic [2:0] {S_MIN, S_MAX, S_ATUAL, S_CMD, S_CLASS, S_MOVE} stateT;
    stateT state, nextState;

    logic [W-1:0]      accMin, accMax, accAtual, accBase, accNext, pendPeso;
    logic [DCNT_W-1:0] digitCnt;
    logic [ICNT_W-1:0] intervalCnt;
    logic [POS_W-1:0]  target;
    logic digitState, isDigit, digitAccept, fieldDone, byteError, windowError;
    logic maxZero, above, below, atTarget;
    logic clsPending, pendPertence, pendAcima, pendAbaixo, pendMaxZero;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no path infers a latch.
        accBase = accAtual;
        if (state == S_MIN)      accBase = accMin;
        else if (state == S_MAX) accBase = accMax;
        // The first digit of a field starts from zero, discarding the previous frame's value.
        if (digitCnt == '0)      accBase = '0;
        isDigit     = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
        accNext     = W'(({4'b0000, accBase} * (W + 4)'(10)) + (W + 4)'(rx_byte[3:0]));
        digitState  = (state == S_MIN) || (state == S_MAX) || (state == S_ATUAL);
        digitAccept = rx_valid && digitState && isDigit;
        fieldDone   = digitAccept && (digitCnt == LAST_DIGIT);
        byteError   = rx_valid && ((digitState && !isDigit) ||
                                   ((state == S_CMD) && (rx_byte != CHAR_HASH)));
        maxZero     = (accMax == '0);
        above       = accAtual > accMax;
        below       = accAtual < accMin;
        windowError = (state == S_CLASS) && !maxZero && (accMin > accMax);
        atTarget    = (posicao == target);
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) state <= S_MIN;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            S_MIN:   if (byteError) nextState = S_MIN; else if (fieldDone) nextState = S_MAX;
            S_MAX:   if (byteError) nextState = S_MIN; else if (fieldDone) nextState = S_ATUAL;
            S_ATUAL: if (byteError) nextState = S_MIN; else if (fieldDone) nextState = S_CMD;
            S_CMD:   if (rx_valid) nextState = byteError ? S_MIN : S_CLASS;
            S_CLASS: nextState = windowError ? S_MIN : S_MOVE;
            S_MOVE:  if (atTarget) nextState = S_MIN;
            default: nextState = S_MIN;
        endcase
    end

    always_comb begin
        movendo = (state == S_MOVE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            accMin <= '0; accMax <= '0; accAtual <= '0; digitCnt <= '0;
            intervalCnt <= '0; target <= '0; posicao <= '0;
            clsPending <= 1'b0; pendPertence <= 1'b0; pendAcima <= 1'b0;
            pendAbaixo <= 1'b0; pendMaxZero <= 1'b0; pendPeso <= '0;
            result_valid <= 1'b0; erro_quadro <= 1'b0; peso_atual <= '0;
            pertence <= 1'b0; acima <= 1'b0; abaixo <= 1'b0; peso_max_zero <= 1'b0;
        end else begin
            erro_quadro  <= byteError || windowError;
            result_valid <= clsPending;
            clsPending   <= 1'b0;

            if (byteError || windowError) begin
                accMin <= '0; accMax <= '0; accAtual <= '0; digitCnt <= '0;
            end else if (digitAccept) begin
                case (state)
                    S_MIN:   accMin   <= accNext;
                    S_MAX:   accMax   <= accNext;
                    default: accAtual <= accNext;
                endcase
                digitCnt <= fieldDone ? '0 : digitCnt + DCNT_W'(1);
            end

            // Classification is staged one cycle before it reaches the outputs.
            if ((state == S_CLASS) && !windowError) begin
                clsPending   <= 1'b1;
                pendMaxZero  <= maxZero;
                pendAcima    <= !maxZero && above;
                pendAbaixo   <= !maxZero && below;
                pendPertence <= !maxZero && !above && !below;
                pendPeso     <= accAtual;
                if (maxZero)    target <= '0;
                else if (below) target <= TGT_ABAIXO;
                else if (above) target <= TGT_ACIMA;
                else            target <= TGT_DENTRO;
            end

            if (clsPending) begin
                pertence      <= pendPertence;
                acima         <= pendAcima;
                abaixo        <= pendAbaixo;
                peso_max_zero <= pendMaxZero;
                peso_atual    <= pendPeso;
            end

            if ((state == S_MOVE) && !atTarget) begin
                if (intervalCnt == LAST_TICK) begin
                    intervalCnt <= '0;
                    posicao     <= (posicao < target) ? posicao + POS_W'(1) : posicao - POS_W'(1);
                end else begin
                    intervalCnt <= intervalCnt + ICNT_W'(1);
                end
            end else begin
                intervalCnt <= '0;
            end
        end
    end

endmodule

// File: doc/classificador_peso_n.md
Name: classificador_peso_n

Overview:
Parametrised weight-classification datapath. It consumes a received byte stream of ASCII frames (minimum, maximum and current weight, then a '#' command) and converts each decimal field to binary. It classifies the current weight against the [min, max] window and drives a servo position that ramps one step per interval toward a class-dependent target. It sits between the UART receiver and the servo PWM generator, and replaces the fixed 16-bit/3-bit datapath.

Parameters:
DIGITS, 4, ASCII digits per field (min, max, current); each field has fixed length
W, 16, binary width of each weight; legal only if 10^DIGITS-1 < 2^W
POS_W, 3, servo position width
STEP_CYCLES, 5_000_000, clock cycles between servo position steps (>=1)
POS_ABAIXO, 0, target position when current < min
POS_DENTRO, 7, target position when min <= current <= max
POS_ACIMA, 4, target position when current > max

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low
rx_valid  in  1  one-cycle strobe: rx_byte holds a received byte
rx_byte  in  8  received byte
result_valid  out  1  one-cycle pulse: classification flags updated
pertence  out  1  min <= current <= max
acima  out  1  current > max
abaixo  out  1  current < min
peso_max_zero  out  1  received max == 0
erro_quadro  out  1  one-cycle pulse: frame rejected
peso_atual  out  W  last classified current weight
posicao  out  POS_W  servo position command
movendo  out  1  high while in S_MOVE

Behaviour:
- Reset (reset=0, async): state S_MIN; accumulators, digit counter and interval counter = 0; all flags, pulses, peso_atual, posicao and movendo = 0.
- Digit conversion: a byte in 0x30..0x39 is a digit. acc <= acc*10 + (byte-0x30), computed W+4 bits wide and truncated to W (no loss under the legal-parameter rule). Fields are MSD first.
- FSM, advancing only on rx_valid except S_CLASS/S_MOVE:
  - S_MIN, S_MAX, S_ATUAL: accept DIGITS digits each, then advance to the next state (S_ATUAL advances to S_CMD).
  - S_CMD: 0x23 ('#') -> S_CLASS; any other byte -> error.
  - S_CLASS (1 cycle): compare the fields, register flags, set target, go to S_MOVE.
  - S_MOVE: ramp posicao toward target, return to S_MIN.
- Error: any non-digit in a digit state, or a non-'#' byte in S_CMD, causes:
  - erro_quadro pulses for 1 cycle; accumulators and digit counter are cleared; state -> S_MIN.
  - Flags, peso_atual and posicao are unchanged.
- Latency: '#' sampled at edge k -> S_CLASS during cycle k..k+1 -> result_valid, flags and peso_atual valid after edge k+2. result_valid is high exactly one cycle. Flags hold until the next result_valid.
- Classification: exactly one of pertence/acima/abaixo is high per valid result. The comparisons are unsigned and the window bounds are inclusive.
- peso_max_zero case (max==0):
  - result_valid pulses with peso_max_zero=1 and pertence=acima=abaixo=0; peso_atual is updated.
  - Target = 0 (home).
- min > max (and max != 0): treated as a frame error. erro_quadro pulses at S_CLASS exit, no result_valid, no movement, state -> S_MIN.
- S_MOVE:
  - movendo=1. The interval counter runs from 0 on entry.
  - On reaching STEP_CYCLES-1, the counter wraps to 0 and posicao moves one step (+1 or -1) toward target.
  - When posicao == target, exit to S_MIN on the next edge and movendo=0. If posicao == target already on entry, exit after 1 cycle with no step.
  - posicao never wraps.
- Bytes arriving in S_CLASS/S_MOVE are dropped silently (no error). The receiver side must space frames accordingly.
- Reset asserted mid-frame or mid-move: immediate return to the reset values, including posicao=0.

Test Plan:
- DIGITS=4, STEP_CYCLES=4: send "0100","0500","0300","#" -> result_valid 2 edges after '#'; pertence=1, peso_atual=300; posicao ramps 0->7, one step per 4 cycles, movendo high for 28 cycles plus 1 exit cycle.
- Next frame "0100","0500","0900","#" -> acima=1, pertence=0; posicao ramps 7->4 in 3 steps. Then current="0050" -> abaixo=1; posicao ramps 4->0.
- Boundaries: current=min=0100 and current=max=0500 each -> pertence=1; max="0000" -> peso_max_zero=1, other flags 0, posicao returns to 0.
- Error paths:
  - Byte 'A' as the 2nd digit of max -> erro_quadro pulse, flags unchanged; a following valid frame classifies correctly.
  - 'X' instead of '#' -> erro_quadro.
  - min=0600 > max=0500 -> erro_quadro, no result_valid.
- A full frame injected during S_MOVE -> bytes dropped, posicao reaches the original target, no result_valid.
- Assert reset mid-field (after 2 digits) and mid-move (posicao=3) -> all outputs 0 asynchronously. After release, a fresh frame classifies normally.
